// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: widths, load-type codes, FSM states.
package wb_stage_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        LD_LB   = 3'd0,
        LD_LBU  = 3'd1,
        LD_LH   = 3'd2,
        LD_LHU  = 3'd3,
        LD_LW   = 3'd4,
        LD_LWL  = 3'd5,
        LD_LWR  = 3'd6,
        LD_RSVD = 3'd7
    } ld_type_e;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load alignment: picks/extends bytes and halfwords and
// builds the partial-word merges for LWL/LWR.
module load_align
    import wb_stage_pkg::*;
(
    input  logic [2:0]            ld_type,
    input  logic [1:0]            addr_lo,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [BE_WIDTH-1:0]   byte_wen
);

    logic [4:0]  sh_lo;
    logic [4:0]  sh_lwl;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [DATA_WIDTH-1:0] byte_shifted;

    // LWL shifts by 3-lo bytes, which for a 2-bit value is simply ~lo.
    assign sh_lo        = {addr_lo, 3'b000};
    assign sh_lwl       = {~addr_lo, 3'b000};
    assign byte_shifted = rdata >> sh_lo;
    assign byte_sel     = byte_shifted[7:0];
    assign half_sel     = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Select data and byte enables according to the load type.
    always_comb begin
        wdata    = rdata;
        byte_wen = '1;
        case (ld_type_e'(ld_type))
            LD_LB:  wdata = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU: wdata = {24'd0, byte_sel};
            LD_LH:  wdata = {{16{half_sel[15]}}, half_sel};
            LD_LHU: wdata = {16'd0, half_sel};
            LD_LWL: begin
                wdata    = rdata << sh_lwl;
                byte_wen = 4'(4'b1111 << ~addr_lo);
            end
            LD_LWR: begin
                wdata    = rdata >> sh_lo;
                byte_wen = 4'b1111 >> addr_lo;
            end
            default: wdata = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers ALU results straight through, parks loads until
// the data memory returns, then writes the aligned value and reports the commit.
//
// state        | meaning
// ST_IDLE      | ready for a new instruction; non-loads retire next cycle
// ST_WAIT_LOAD | load latched, waiting for dmem_rvalid
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH = wb_stage_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = wb_stage_pkg::ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_pc,
    input  logic [ADDR_WIDTH-1:0]   in_rd,
    input  logic                    in_is_load,
    input  logic [2:0]              in_ld_type,
    input  logic [1:0]              in_addr_lo,
    input  logic [DATA_WIDTH-1:0]   in_result,
    input  logic                    dmem_rvalid,
    input  logic [DATA_WIDTH-1:0]   dmem_rdata,
    output logic [ADDR_WIDTH-1:0]   rf_waddr,
    output logic [DATA_WIDTH/8-1:0] rf_byte_wen,
    output logic [DATA_WIDTH-1:0]   rf_wdata,
    output logic                    commit_valid,
    output logic [31:0]             commit_pc
);

    wb_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0]   ld_rd_q, ld_rd_d;
    logic [2:0]              ld_type_q, ld_type_d;
    logic [1:0]              ld_lo_q, ld_lo_d;
    logic [31:0]             ld_pc_q, ld_pc_d;

    logic [ADDR_WIDTH-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH/8-1:0] rf_byte_wen_q, rf_byte_wen_d;
    logic [DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
    logic                    commit_valid_q, commit_valid_d;
    logic [31:0]             commit_pc_q, commit_pc_d;

    logic [DATA_WIDTH-1:0]   al_wdata;
    logic [DATA_WIDTH/8-1:0] al_byte_wen;

    load_align u_load_align (
        .ld_type  (ld_type_q),
        .addr_lo  (ld_lo_q),
        .rdata    (dmem_rdata),
        .wdata    (al_wdata),
        .byte_wen (al_byte_wen)
    );

    assign in_ready = (state_q == ST_IDLE);

    // Next-state and next-output logic; outputs default to an idle (no-write) cycle.
    always_comb begin
        state_d        = state_q;
        ld_rd_d        = ld_rd_q;
        ld_type_d      = ld_type_q;
        ld_lo_d        = ld_lo_q;
        ld_pc_d        = ld_pc_q;
        rf_waddr_d     = '0;
        rf_byte_wen_d  = '0;
        rf_wdata_d     = '0;
        commit_valid_d = 1'b0;
        commit_pc_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_is_load) begin
                        ld_rd_d   = in_rd;
                        ld_type_d = in_ld_type;
                        ld_lo_d   = in_addr_lo;
                        ld_pc_d   = in_pc;
                        state_d   = ST_WAIT_LOAD;
                    end else begin
                        rf_waddr_d     = in_rd;
                        rf_byte_wen_d  = (in_rd == '0) ? '0 : '1;
                        rf_wdata_d     = in_result;
                        commit_valid_d = 1'b1;
                        commit_pc_d    = in_pc;
                    end
                end
            end
            ST_WAIT_LOAD: begin
                if (dmem_rvalid) begin
                    rf_waddr_d     = ld_rd_q;
                    rf_byte_wen_d  = (ld_rd_q == '0) ? '0 : al_byte_wen;
                    rf_wdata_d     = al_wdata;
                    commit_valid_d = 1'b1;
                    commit_pc_d    = ld_pc_q;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched load context and registered writeback outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            ld_rd_q        <= '0;
            ld_type_q      <= '0;
            ld_lo_q        <= '0;
            ld_pc_q        <= '0;
            rf_waddr_q     <= '0;
            rf_byte_wen_q  <= '0;
            rf_wdata_q     <= '0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
        end else begin
            state_q        <= state_d;
            ld_rd_q        <= ld_rd_d;
            ld_type_q      <= ld_type_d;
            ld_lo_q        <= ld_lo_d;
            ld_pc_q        <= ld_pc_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_byte_wen_q  <= rf_byte_wen_d;
            rf_wdata_q     <= rf_wdata_d;
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
        end
    end

    assign rf_waddr     = rf_waddr_q;
    assign rf_byte_wen  = rf_byte_wen_q;
    assign rf_wdata     = rf_wdata_q;
    assign commit_valid = commit_valid_q;
    assign commit_pc    = commit_pc_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage with hand-computed expected values.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rd;
    logic        in_is_load;
    logic [2:0]  in_ld_type;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_result;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [4:0]  rf_waddr;
    logic [3:0]  rf_byte_wen;
    logic [31:0] rf_wdata;
    logic        commit_valid;
    logic [31:0] commit_pc;

    int checks = 0;
    int errors = 0;
    int busy_cycles;

    wb_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_rd        (in_rd),
        .in_is_load   (in_is_load),
        .in_ld_type   (in_ld_type),
        .in_addr_lo   (in_addr_lo),
        .in_result    (in_result),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .rf_waddr     (rf_waddr),
        .rf_byte_wen  (rf_byte_wen),
        .rf_wdata     (rf_wdata),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_out(input string tag);
        chk({tag, ".commit_valid"}, 32'(commit_valid), 32'd0);
        chk({tag, ".byte_wen"},     32'(rf_byte_wen),  32'd0);
        chk({tag, ".waddr"},        32'(rf_waddr),     32'd0);
        chk({tag, ".wdata"},        rf_wdata,          32'd0);
    endtask

    // Present one load, return data after 'delay' empty cycles, check the write.
    task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] ty,
                           input logic [1:0] lo, input logic [31:0] pc,
                           input logic [31:0] rdata, input int delay,
                           input logic [3:0] exp_wen, input logic [31:0] exp_wdata);
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_rd      = rd;
        in_ld_type = ty;
        in_addr_lo = lo;
        in_pc      = pc;
        chk({tag, ".ready_before"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk({tag, ".ready_wait"}, 32'(in_ready), 32'd0);
        chk({tag, ".no_early_commit"}, 32'(commit_valid), 32'd0);
        repeat (delay) step();
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        step();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        chk({tag, ".commit_valid"}, 32'(commit_valid), 32'd1);
        chk({tag, ".commit_pc"},    commit_pc,         pc);
        chk({tag, ".waddr"},        32'(rf_waddr),     32'(rd));
        chk({tag, ".byte_wen"},     32'(rf_byte_wen),  32'(exp_wen));
        if (exp_wen != 4'h0) chk({tag, ".wdata"}, rf_wdata, exp_wdata);
        chk({tag, ".ready_after"},  32'(in_ready),     32'd1);
        step();
        chk({tag, ".single_cycle"}, 32'(commit_valid), 32'd0);
    endtask

    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_pc       = 32'h0;
        in_rd       = 5'd0;
        in_is_load  = 1'b0;
        in_ld_type  = 3'd0;
        in_addr_lo  = 2'd0;
        in_result   = 32'h0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;

        // Reset: outputs zero, ready high.
        #2;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk_idle_out("rst");
        step();
        step();
        rst = 1'b1;
        chk("post_rst.in_ready", 32'(in_ready), 32'd1);

        // Two back-to-back non-loads.
        in_valid   = 1'b1;
        in_is_load = 1'b0;
        in_rd      = 5'd3;
        in_result  = 32'h1234_5678;
        in_pc      = 32'h0000_0100;
        step();
        chk("add1.waddr",    32'(rf_waddr),     32'd3);
        chk("add1.byte_wen", 32'(rf_byte_wen),  32'hF);
        chk("add1.wdata",    rf_wdata,          32'h1234_5678);
        chk("add1.commit",   32'(commit_valid), 32'd1);
        chk("add1.pc",       commit_pc,         32'h0000_0100);
        chk("add1.ready",    32'(in_ready),     32'd1);
        in_rd     = 5'd5;
        in_result = 32'hCAFE_F00D;
        in_pc     = 32'h0000_0104;
        step();
        chk("add2.waddr",  32'(rf_waddr),     32'd5);
        chk("add2.wdata",  rf_wdata,          32'hCAFE_F00D);
        chk("add2.commit", 32'(commit_valid), 32'd1);
        chk("add2.pc",     commit_pc,         32'h0000_0104);
        in_valid = 1'b0;
        step();
        chk_idle_out("gap");

        // Alignment cases.
        do_load("lb",   5'd4,  3'd0, 2'd2, 32'h200, 32'h0080_FF00, 0, 4'hF, 32'hFFFF_FF80);
        do_load("lbu",  5'd4,  3'd1, 2'd2, 32'h204, 32'h0080_FF00, 1, 4'hF, 32'h0000_0080);
        do_load("lwl",  5'd6,  3'd5, 2'd1, 32'h208, 32'hAABB_CCDD, 0, 4'b1100, 32'hCCDD_0000);
        do_load("lwr",  5'd6,  3'd6, 2'd2, 32'h20C, 32'hAABB_CCDD, 0, 4'b0011, 32'h0000_AABB);
        do_load("lwl0", 5'd6,  3'd5, 2'd0, 32'h210, 32'hAABB_CCDD, 0, 4'b1000, 32'hDD00_0000);
        do_load("lwr3", 5'd6,  3'd6, 2'd3, 32'h214, 32'hAABB_CCDD, 0, 4'b0001, 32'h0000_00AA);
        do_load("lh",   5'd8,  3'd2, 2'd3, 32'h218, 32'h8001_7FFF, 0, 4'hF, 32'hFFFF_8001);
        do_load("lhu",  5'd8,  3'd3, 2'd1, 32'h21C, 32'h8001_7FFF, 0, 4'hF, 32'h0000_7FFF);
        do_load("lw",   5'd9,  3'd4, 2'd3, 32'h220, 32'hDEAD_BEEF, 0, 4'hF, 32'hDEAD_BEEF);
        do_load("rsvd", 5'd10, 3'd7, 2'd2, 32'h224, 32'h0102_0304, 0, 4'hF, 32'h0102_0304);
        do_load("rd0",  5'd0,  3'd4, 2'd0, 32'h228, 32'h1111_2222, 0, 4'h0, 32'h0);

        // Spurious rvalid in IDLE.
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5A5A_5A5A;
        step();
        dmem_rvalid = 1'b0;
        chk_idle_out("spurious");
        chk("spurious.ready", 32'(in_ready), 32'd1);

        // Delayed load with in_valid held; rvalid in the acceptance cycle is ignored.
        in_valid    = 1'b1;
        in_is_load  = 1'b1;
        in_rd       = 5'd7;
        in_ld_type  = 3'd4;
        in_addr_lo  = 2'd0;
        in_pc       = 32'h300;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hBAD0_BAD0;
        step();
        dmem_rvalid = 1'b0;
        in_is_load  = 1'b0;
        in_rd       = 5'd9;
        in_result   = 32'h0000_0055;
        in_pc       = 32'h304;
        chk("hold.no_consume", 32'(commit_valid), 32'd0);
        busy_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            if (!in_ready) busy_cycles++;
            step();
            chk("hold.no_commit", 32'(commit_valid), 32'd0);
        end
        if (!in_ready) busy_cycles++;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h7777_8888;
        step();
        dmem_rvalid = 1'b0;
        chk("hold.busy_cycles", 32'(busy_cycles), 32'd6);
        chk("hold.ld_commit",   32'(commit_valid), 32'd1);
        chk("hold.ld_waddr",    32'(rf_waddr),     32'd7);
        chk("hold.ld_wdata",    rf_wdata,          32'h7777_8888);
        chk("hold.ld_pc",       commit_pc,         32'h300);
        chk("hold.ready",       32'(in_ready),     32'd1);
        step();
        in_valid = 1'b0;
        chk("hold.next_commit", 32'(commit_valid), 32'd1);
        chk("hold.next_waddr",  32'(rf_waddr),     32'd9);
        chk("hold.next_wdata",  rf_wdata,          32'h0000_0055);
        chk("hold.next_pc",     commit_pc,         32'h304);
        step();
        chk_idle_out("hold.after");

        // Reset while waiting for load data: load is dropped.
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_rd      = 5'd12;
        in_ld_type = 3'd4;
        in_pc      = 32'h400;
        step();
        in_valid = 1'b0;
        chk("rstwait.busy", 32'(in_ready), 32'd0);
        #3;
        rst = 1'b0;
        #1;
        chk("rstwait.ready_in_rst", 32'(in_ready), 32'd1);
        #2;
        rst = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFF_0000;
        step();
        dmem_rvalid = 1'b0;
        chk_idle_out("rstwait");
        chk("rstwait.ready", 32'(in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32: register and data-memory word width; only 32 is supported.
REQ-002 Parameter ADDR_WIDTH, default 5: register-file address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  memory stage presents an instruction.
REQ-006 in_ready  out  1  stage can accept; transfer occurs when in_valid && in_ready.
REQ-007 in_pc  in  32  instruction PC, used for commit trace.
REQ-008 in_rd  in  ADDR_WIDTH  destination register.
REQ-009 in_is_load  in  1  instruction is a load.
REQ-010 in_ld_type  in  3  load type: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR.
REQ-011 in_addr_lo  in  2  load byte address bits [1:0].
REQ-012 in_result  in  DATA_WIDTH  ALU/link result for non-loads.
REQ-013 dmem_rvalid  in  1  load data valid, one-cycle pulse.
REQ-014 dmem_rdata  in  DATA_WIDTH  little-endian load word.
REQ-015 rf_waddr  out  ADDR_WIDTH  register-file write address.
REQ-016 rf_byte_wen  out  DATA_WIDTH/8  register-file byte write enables.
REQ-017 rf_wdata  out  DATA_WIDTH  register-file write data.
REQ-018 commit_valid  out  1  instruction retired this cycle.
REQ-019 commit_pc  out  32  PC of retiring instruction.

Function
REQ-020 FSM states SHALL be IDLE and WAIT_LOAD; in_ready SHALL be 1 only in IDLE.
REQ-021 Non-load accepted in IDLE: rf_* and commit_* SHALL be driven from registers in the next cycle for exactly one cycle, byte_wen 4'hF, wdata in_result; state stays IDLE (throughput one per cycle).
REQ-022 Load accepted in IDLE: rd, ld_type, addr_lo, pc SHALL be latched and the FSM SHALL enter WAIT_LOAD.
REQ-023 In WAIT_LOAD, dmem_rvalid SHALL cause the aligned write and commit to appear in the next cycle and the FSM to return to IDLE; with no rvalid the state SHALL hold indefinitely.
REQ-024 dmem_rvalid in IDLE SHALL be ignored; dmem_rvalid in the acceptance cycle of a load SHALL NOT be consumed.
REQ-025 LB/LBU: byte dmem_rdata[8*lo+7:8*lo], sign-/zero-extended, byte_wen 4'hF.
REQ-026 LH/LHU: halfword selected by lo[1] (lo[0] ignored), sign-/zero-extended, byte_wen 4'hF.
REQ-027 LW: wdata dmem_rdata, byte_wen 4'hF, addr_lo ignored.
REQ-028 LWL: lo 0/1/2/3 -> byte_wen 4'b1000/1100/1110/1111, wdata dmem_rdata shifted left 24/16/8/0 bits.
REQ-029 LWR: lo 0/1/2/3 -> byte_wen 4'b1111/0111/0011/0001, wdata dmem_rdata shifted right 0/8/16/24 bits.
REQ-030 Reserved ld_type 7 SHALL behave as LW.
REQ-031 rd == 0: byte_wen SHALL be 4'h0, commit_valid still asserted.
REQ-032 In any cycle with no write, rf_byte_wen SHALL be 0, rf_waddr 0, rf_wdata 0, commit_valid 0.

Reset
REQ-033 Reset assertion SHALL immediately force state IDLE and all outputs to 0 except in_ready; a pending load SHALL be discarded with no write.
REQ-034 in_ready SHALL be 1 during and after reset.

Structure
REQ-035 DATA_WIDTH, ADDR_WIDTH, the ld_type encodings and the FSM state encodings SHALL live in the shared common header.
REQ-036 Byte/halfword/LWL/LWR alignment SHALL be a combinational sub-module load_align (inputs ld_type, addr_lo, rdata; outputs wdata, byte_wen).

Verification
REQ-037 ADD rd=3 result 0x12345678 -> next cycle waddr 3, byte_wen F, wdata 0x12345678, commit_valid 1.
REQ-038 LB lo=2, rdata 0x0080FF00 -> byte_wen F, wdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-039 LWL lo=1, rdata 0xAABBCCDD -> byte_wen 1100, wdata 0xCCDD0000; LWR lo=2 -> byte_wen 0011, wdata 0x0000AABB.
REQ-040 Load with rvalid delayed 5 cycles while in_valid held -> in_ready 0 for 6 cycles, one write, then next instruction accepted.
REQ-041 rd=0 LW -> byte_wen 0, commit_valid 1; spurious rvalid in IDLE -> no write.
REQ-042 Reset asserted in WAIT_LOAD, then rvalid after release -> no write, in_ready 1.
